// File: rtl/decode_forward_issue.sv
// decode_forward_issue
//   N-lane decode-to-EX issue stage. For each lane it picks every source
//   operand from the youngest in-flight producer (EX, then MEM, then WB, then
//   the register file). It detects load-use, D-cache-miss and intra-bundle RAW
//   hazards, splits a bundle in order across cycles, and owns the ID/EX
//   valid/operand registers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 drop everything in ID/EX and restart the bundle
//   ex_stall              EX cannot accept: hold all state
//   dec_*                 decoded bundle (valid, sources, destination)
//   rf_rs1/rs2_data       register-file read data per lane
//   ex_* / mem_* / wb_*   in-flight producers per lane
//   dec_ready             bundle fully issued this cycle (combinational)
//   idex_valid/rs*_data   registered issue valid and forwarded operands
//   hz_partial            a bundle is partly issued
//   hz_stall_cnt          saturating count of hazard-split cycles
module decode_forward_issue #(
   parameter int ISSUE_NUM     = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int RF_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               ex_stall,
   input  logic [ISSUE_NUM-1:0]               dec_valid,
   output logic                               dec_ready,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] dec_rs1_addr,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] dec_rs2_addr,
   input  logic [ISSUE_NUM-1:0]               dec_rs1_en,
   input  logic [ISSUE_NUM-1:0]               dec_rs2_en,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    rf_rs1_data,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    rf_rs2_data,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] dec_rd_addr,
   input  logic [ISSUE_NUM-1:0]               dec_rd_wen,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic [ISSUE_NUM-1:0]               ex_rd_wen,
   input  logic [ISSUE_NUM-1:0]               ex_is_load,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    ex_alu_data,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [ISSUE_NUM-1:0]               mem_rd_wen,
   input  logic [ISSUE_NUM-1:0]               mem_is_load,
   input  logic [ISSUE_NUM-1:0]               mem_ld_done,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    mem_alu_data,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    dcache_rd_data,
   input  logic [ISSUE_NUM*RF_ADDR_WIDTH-1:0] wb_rd_addr,
   input  logic [ISSUE_NUM-1:0]               wb_rd_wen,
   input  logic [ISSUE_NUM*DATA_WIDTH-1:0]    wb_data,
   output logic [ISSUE_NUM-1:0]               idex_valid,
   output logic [ISSUE_NUM*DATA_WIDTH-1:0]    idex_rs1_data,
   output logic [ISSUE_NUM*DATA_WIDTH-1:0]    idex_rs2_data,
   output logic                               hz_partial,
   output logic [CNT_WIDTH-1:0]               hz_stall_cnt
);

   localparam int AW = RF_ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   typedef enum logic {RUN, PARTIAL} stateT;

   stateT                 stateReg, stateNext;
   logic [ISSUE_NUM-1:0]  doneMaskReg, doneMaskNext;
   logic [ISSUE_NUM-1:0]  validReg, validNext;
   logic [CNT_WIDTH-1:0]  cntReg, cntNext;
   logic [ISSUE_NUM-1:0]  eligible, laneHz, issued;
   logic                  blocked, allIssued;

   // Lanes already issued in an earlier cycle of this bundle are masked off.
   assign eligible = dec_valid & ~doneMaskReg;

   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_NUM; gi++) begin : gLane
         logic [1:0][AW-1:0] srcAddr;
         logic [1:0]         srcEn;
         logic [1:0][DW-1:0] srcRf, srcData;
         logic               hz, exAluHit, memHit, wbHit;
         logic [DW-1:0]      rs1Reg, rs2Reg;

         assign srcAddr[0] = dec_rs1_addr[gi*AW +: AW];
         assign srcAddr[1] = dec_rs2_addr[gi*AW +: AW];
         assign srcEn[0]   = dec_rs1_en[gi];
         assign srcEn[1]   = dec_rs2_en[gi];
         assign srcRf[0]   = rf_rs1_data[gi*DW +: DW];
         assign srcRf[1]   = rf_rs2_data[gi*DW +: DW];

         // Priority: younger lanes inside a stage win, and an EX ALU hit hides
         // any older MEM/WB producer of the same register. Any load still in
         // EX that writes the source is a load-use hazard regardless.
         always_comb begin
            hz       = 1'b0;
            srcData  = srcRf;
            exAluHit = 1'b0;
            memHit   = 1'b0;
            wbHit    = 1'b0;
            for (int s = 0; s < 2; s++) begin
               exAluHit = 1'b0;
               memHit   = 1'b0;
               wbHit    = 1'b0;
               if (srcEn[s] && srcAddr[s] != '0) begin
                  for (int e = ISSUE_NUM-1; e >= 0; e--) begin
                     if (ex_rd_wen[e] && ex_rd_addr[e*AW +: AW] == srcAddr[s]) begin
                        if (ex_is_load[e]) begin
                           hz = 1'b1;
                        end else if (!exAluHit) begin
                           exAluHit   = 1'b1;
                           srcData[s] = ex_alu_data[e*DW +: DW];
                        end
                     end
                  end
                  for (int m = ISSUE_NUM-1; m >= 0; m--) begin
                     if (!exAluHit && !memHit && mem_rd_wen[m] &&
                         mem_rd_addr[m*AW +: AW] == srcAddr[s]) begin
                        memHit = 1'b1;
                        if (mem_is_load[m]) begin
                           srcData[s] = dcache_rd_data[m*DW +: DW];
                           if (!mem_ld_done[m]) hz = 1'b1;
                        end else begin
                           srcData[s] = mem_alu_data[m*DW +: DW];
                        end
                     end
                  end
                  for (int w = ISSUE_NUM-1; w >= 0; w--) begin
                     if (!exAluHit && !memHit && !wbHit && wb_rd_wen[w] &&
                         wb_rd_addr[w*AW +: AW] == srcAddr[s]) begin
                        wbHit      = 1'b1;
                        srcData[s] = wb_data[w*DW +: DW];
                     end
                  end
                  // RAW on an older lane of the same bundle that has not issued yet.
                  for (int j = 0; j < gi; j++) begin
                     if (eligible[j] && dec_rd_wen[j] &&
                         dec_rd_addr[j*AW +: AW] == srcAddr[s]) hz = 1'b1;
                  end
               end
            end
         end

         assign laneHz[gi] = hz;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rs1Reg <= '0;
               rs2Reg <= '0;
            end else if (!flush && !ex_stall && issued[gi]) begin
               rs1Reg <= srcData[0];
               rs2Reg <= srcData[1];
            end
         end

         assign idex_rs1_data[gi*DW +: DW] = rs1Reg;
         assign idex_rs2_data[gi*DW +: DW] = rs2Reg;
      end
   endgenerate

   // In-order issue: stop at the first eligible lane with a hazard.
   always_comb begin
      issued  = '0;
      blocked = 1'b0;
      for (int i = 0; i < ISSUE_NUM; i++) begin
         if (eligible[i] && !blocked) begin
            if (laneHz[i]) blocked = 1'b1;
            else           issued[i] = 1'b1;
         end
      end
   end

   assign allIssued = (issued == eligible);
   assign dec_ready = rst_n & ~flush & ~ex_stall & allIssued;

   always_comb begin
      stateNext    = stateReg;
      doneMaskNext = doneMaskReg;
      validNext    = validReg;
      cntNext      = cntReg;
      if (flush) begin
         stateNext    = RUN;
         doneMaskNext = '0;
         validNext    = '0;
      end else if (!ex_stall) begin
         validNext = issued;
         if (allIssued) begin
            stateNext    = RUN;
            doneMaskNext = '0;
         end else begin
            stateNext    = PARTIAL;
            doneMaskNext = doneMaskReg | issued;
            if (cntReg != '1) cntNext = cntReg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg    <= RUN;
         doneMaskReg <= '0;
         validReg    <= '0;
         cntReg      <= '0;
      end else begin
         stateReg    <= stateNext;
         doneMaskReg <= doneMaskNext;
         validReg    <= validNext;
         cntReg      <= cntNext;
      end
   end

   assign idex_valid   = validReg;
   assign hz_partial   = (stateReg == PARTIAL);
   assign hz_stall_cnt = cntReg;

endmodule

// File: tb/tb_decode_forward_issue.sv
// Testbench for decode_forward_issue: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// producer-list reference model.
module tb_decode_forward_issue;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, flush, ex_stall;
   logic [N-1:0] decValid, decRs1En, decRs2En, decRdWen;
   logic [N-1:0] exRdWen, exIsLoad, memRdWen, memIsLoad, memLdDone, wbRdWen;
   logic [N-1:0][AW-1:0] decRs1Addr, decRs2Addr, decRdAddr, exRdAddr, memRdAddr, wbRdAddr;
   logic [N-1:0][DW-1:0] rfRs1, rfRs2, exAlu, memAlu, dcache, wbData;
   logic [N-1:0][DW-1:0] idexRs1, idexRs2;
   logic [N-1:0] idexValid;
   logic decReady, hzPartial;
   logic [CW-1:0] hzCnt;

   decode_forward_issue #(.ISSUE_NUM(N), .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_stall(ex_stall),
      .dec_valid(decValid), .dec_ready(decReady),
      .dec_rs1_addr(decRs1Addr), .dec_rs2_addr(decRs2Addr),
      .dec_rs1_en(decRs1En), .dec_rs2_en(decRs2En),
      .rf_rs1_data(rfRs1), .rf_rs2_data(rfRs2),
      .dec_rd_addr(decRdAddr), .dec_rd_wen(decRdWen),
      .ex_rd_addr(exRdAddr), .ex_rd_wen(exRdWen), .ex_is_load(exIsLoad), .ex_alu_data(exAlu),
      .mem_rd_addr(memRdAddr), .mem_rd_wen(memRdWen), .mem_is_load(memIsLoad),
      .mem_ld_done(memLdDone), .mem_alu_data(memAlu), .dcache_rd_data(dcache),
      .wb_rd_addr(wbRdAddr), .wb_rd_wen(wbRdWen), .wb_data(wbData),
      .idex_valid(idexValid), .idex_rs1_data(idexRs1), .idex_rs2_data(idexRs2),
      .hz_partial(hzPartial), .hz_stall_cnt(hzCnt)
   );

   int checks = 0;
   int errors = 0;
   logic cmpEn = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Producers listed youngest first. kind 0 = value available,
   // 1 = load still in EX, 2 = load in MEM waiting for the D-cache.
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] val;
      int            kind;
   } prodT;
   prodT prodQ[$];

   logic [N-1:0]         mValid, mDone;
   logic [N-1:0][DW-1:0] mRs1, mRs2;
   logic                 mPartial;
   logic [CW-1:0]        mCnt;

   function automatic void buildProducers();
      prodT p;
      prodQ.delete();
      for (int e = N-1; e >= 0; e--)
         if (exRdWen[e]) begin
            p.addr = exRdAddr[e]; p.val = exAlu[e]; p.kind = exIsLoad[e] ? 1 : 0;
            prodQ.push_back(p);
         end
      for (int m = N-1; m >= 0; m--)
         if (memRdWen[m]) begin
            p.addr = memRdAddr[m];
            p.val  = memIsLoad[m] ? dcache[m] : memAlu[m];
            p.kind = (memIsLoad[m] && !memLdDone[m]) ? 2 : 0;
            prodQ.push_back(p);
         end
      for (int w = N-1; w >= 0; w--)
         if (wbRdWen[w]) begin
            p.addr = wbRdAddr[w]; p.val = wbData[w]; p.kind = 0;
            prodQ.push_back(p);
         end
   endfunction

   function automatic void srcLookup(input logic [AW-1:0] a, input logic en, input logic [DW-1:0] rf,
                                     output logic [DW-1:0] d, output logic hz);
      d  = rf;
      hz = 1'b0;
      if (!en || a == '0) return;
      for (int k = 0; k < prodQ.size(); k++)
         if (prodQ[k].addr == a && prodQ[k].kind == 1) hz = 1'b1;
      if (hz) return;
      for (int k = 0; k < prodQ.size(); k++)
         if (prodQ[k].addr == a && prodQ[k].kind != 1) begin
            if (prodQ[k].kind == 2) hz = 1'b1;
            else d = prodQ[k].val;
            return;
         end
   endfunction

   function automatic void modelEval(output logic [N-1:0] iss, output logic [N-1:0][DW-1:0] r1,
                                     output logic [N-1:0][DW-1:0] r2, output logic all);
      logic [(1<<AW)-1:0] pend;
      logic [N-1:0] elig;
      logic blk, h1, h2, hz;
      logic [DW-1:0] d1, d2;
      buildProducers();
      pend = '0; blk = 1'b0; iss = '0; r1 = '0; r2 = '0;
      elig = decValid & ~mDone;
      for (int i = 0; i < N; i++) begin
         srcLookup(decRs1Addr[i], decRs1En[i], rfRs1[i], d1, h1);
         srcLookup(decRs2Addr[i], decRs2En[i], rfRs2[i], d2, h2);
         r1[i] = d1;
         r2[i] = d2;
         if (!elig[i]) continue;
         hz = h1 || h2 ||
              (decRs1En[i] && decRs1Addr[i] != '0 && pend[decRs1Addr[i]]) ||
              (decRs2En[i] && decRs2Addr[i] != '0 && pend[decRs2Addr[i]]);
         if (!blk) begin
            if (hz) blk = 1'b1;
            else iss[i] = 1'b1;
         end
         if (decRdWen[i]) pend[decRdAddr[i]] = 1'b1;
      end
      all = (iss == elig);
   endfunction

   always @(posedge clk) begin
      logic [N-1:0] iss;
      logic [N-1:0][DW-1:0] r1, r2;
      logic all;
      modelEval(iss, r1, r2, all);
      if (!rst_n) begin
         mValid <= '0; mDone <= '0; mPartial <= 1'b0; mCnt <= '0; mRs1 <= '0; mRs2 <= '0;
      end else if (flush) begin
         mValid <= '0; mDone <= '0; mPartial <= 1'b0;
      end else if (!ex_stall) begin
         mValid <= iss;
         for (int l = 0; l < N; l++)
            if (iss[l]) begin
               mRs1[l] <= r1[l];
               mRs2[l] <= r2[l];
            end
         if (all) begin
            mDone <= '0; mPartial <= 1'b0;
         end else begin
            mDone <= mDone | iss; mPartial <= 1'b1;
            if (mCnt != '1) mCnt <= mCnt + 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic [N-1:0] iss;
      logic [N-1:0][DW-1:0] r1, r2;
      logic all;
      if (cmpEn) begin
         modelEval(iss, r1, r2, all);
         check("model dec_ready", 64'(decReady), 64'(rst_n && !flush && !ex_stall && all));
         check("model idex_valid", 64'(idexValid), 64'(mValid));
         check("model hz_partial", 64'(hzPartial), 64'(mPartial));
         check("model hz_stall_cnt", 64'(hzCnt), 64'(mCnt));
         for (int l = 0; l < N; l++)
            if (mValid[l]) begin
               check($sformatf("model idex_rs1[%0d]", l), 64'(idexRs1[l]), 64'(mRs1[l]));
               check($sformatf("model idex_rs2[%0d]", l), 64'(idexRs2[l]), 64'(mRs2[l]));
            end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clearAll();
      flush = 0; ex_stall = 0;
      decValid = '0; decRs1En = '0; decRs2En = '0; decRdWen = '0;
      exRdWen = '0; exIsLoad = '0; memRdWen = '0; memIsLoad = '0; memLdDone = '0; wbRdWen = '0;
      decRs1Addr = '0; decRs2Addr = '0; decRdAddr = '0; exRdAddr = '0; memRdAddr = '0; wbRdAddr = '0;
      rfRs1 = '0; rfRs2 = '0; exAlu = '0; memAlu = '0; dcache = '0; wbData = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bundleWbForward();
      clearAll();
      decValid = 2'b11;
      decRdWen[0] = 1; decRdAddr[0] = 5; decRs1En[0] = 1; decRs1Addr[0] = 1; rfRs1[0] = 32'h11;
      decRs1En[1] = 1; decRs1Addr[1] = 6; rfRs1[1] = 32'h999;
      wbRdWen[0] = 1; wbRdAddr[0] = 6; wbData[0] = 32'h1234;
   endtask

   task automatic bundleIntraRaw();
      clearAll();
      decValid = 2'b11;
      decRdWen[0] = 1; decRdAddr[0] = 7;
      decRs1En[1] = 1; decRs1Addr[1] = 7; rfRs1[1] = 32'h777;
   endtask

   logic lastReady;

   initial begin
      clearAll();
      rst_n = 0;
      tick();
      cmpEn = 1;
      tick();
      check("reset idex_valid", 64'(idexValid), 64'(0));
      check("reset idex_rs1", 64'(idexRs1), 64'(0));
      check("reset hz_partial", 64'(hzPartial), 64'(0));
      check("reset hz_stall_cnt", 64'(hzCnt), 64'(0));
      check("reset dec_ready", 64'(decReady), 64'(0));
      rst_n = 1;

      // WB forwarding into lane1, both lanes issue together
      bundleWbForward();
      #1 check("t1 dec_ready", 64'(decReady), 64'(1));
      tick();
      check("t1 idex_valid", 64'(idexValid), 64'(2'b11));
      check("t1 lane1 rs1", 64'(idexRs1[1]), 64'(32'h1234));
      check("t1 lane0 rs1", 64'(idexRs1[0]), 64'(32'h11));

      // intra-bundle RAW splits the bundle, second half forwarded from EX
      bundleIntraRaw();
      #1 check("t2 dec_ready c1", 64'(decReady), 64'(0));
      tick();
      check("t2 idex_valid c1", 64'(idexValid), 64'(2'b01));
      check("t2 hz_partial c1", 64'(hzPartial), 64'(1));
      check("t2 cnt c1", 64'(hzCnt), 64'(1));
      exRdWen[0] = 1; exRdAddr[0] = 7; exAlu[0] = 32'hBEEF;
      #1 check("t2 dec_ready c2", 64'(decReady), 64'(1));
      tick();
      check("t2 idex_valid c2", 64'(idexValid), 64'(2'b10));
      check("t2 lane1 rs1", 64'(idexRs1[1]), 64'(32'hBEEF));
      check("t2 hz_partial c2", 64'(hzPartial), 64'(0));

      // load-use on EX lane1, resolved next cycle from MEM
      clearAll();
      decValid = 2'b01; decRs1En[0] = 1; decRs1Addr[0] = 3;
      exRdWen[1] = 1; exRdAddr[1] = 3; exIsLoad[1] = 1;
      #1 check("t3 dec_ready stall", 64'(decReady), 64'(0));
      tick();
      check("t3 idex_valid stall", 64'(idexValid), 64'(0));
      check("t3 cnt", 64'(hzCnt), 64'(2));
      exRdWen = '0; exIsLoad = '0;
      memRdWen[1] = 1; memRdAddr[1] = 3; memIsLoad[1] = 1; memLdDone[1] = 1; dcache[1] = 32'hCAFE;
      #1 check("t3 dec_ready go", 64'(decReady), 64'(1));
      tick();
      check("t3 idex_valid go", 64'(idexValid), 64'(2'b01));
      check("t3 lane0 rs1", 64'(idexRs1[0]), 64'(32'hCAFE));

      // D-cache miss for three cycles
      clearAll();
      decValid = 2'b01; decRs2En[0] = 1; decRs2Addr[0] = 4;
      memRdWen[0] = 1; memRdAddr[0] = 4; memIsLoad[0] = 1; memLdDone[0] = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4 bubble idex_valid", 64'(idexValid), 64'(0));
      end
      check("t4 cnt", 64'(hzCnt), 64'(5));
      memLdDone[0] = 1; dcache[0] = 32'h4444;
      tick();
      check("t4 idex_valid", 64'(idexValid), 64'(2'b01));
      check("t4 lane0 rs2", 64'(idexRs2[0]), 64'(32'h4444));
      check("t4 cnt hold", 64'(hzCnt), 64'(5));

      // EX beats MEM; x0 always takes RF data
      clearAll();
      decValid = 2'b11;
      decRs1En[0] = 1; decRs1Addr[0] = 9; rfRs1[0] = 32'h90;
      decRs1En[1] = 1; decRs1Addr[1] = 0; rfRs1[1] = 32'h0;
      exRdWen[0] = 1; exRdAddr[0] = 9; exAlu[0] = 32'h1;
      memRdWen[1] = 1; memRdAddr[1] = 9; memAlu[1] = 32'h2;
      exRdWen[1] = 1; exRdAddr[1] = 0; exAlu[1] = 32'hDEAD;
      tick();
      check("t5 idex_valid", 64'(idexValid), 64'(2'b11));
      check("t5 lane0 ex wins", 64'(idexRs1[0]), 64'(32'h1));
      check("t5 lane1 x0", 64'(idexRs1[1]), 64'(32'h0));

      // flush during PARTIAL
      bundleIntraRaw();
      tick();
      check("t6 hz_partial", 64'(hzPartial), 64'(1));
      check("t6 cnt", 64'(hzCnt), 64'(6));
      flush = 1;
      #1 check("t6 dec_ready flush", 64'(decReady), 64'(0));
      tick();
      check("t6 idex_valid flush", 64'(idexValid), 64'(0));
      check("t6 hz_partial flush", 64'(hzPartial), 64'(0));

      // ex_stall holds everything for two cycles
      bundleWbForward();
      tick();
      check("t7 idex_valid", 64'(idexValid), 64'(2'b11));
      ex_stall = 1; decValid = 2'b01; wbData[0] = 32'h5555; decRdAddr[0] = 7; decRs1Addr[1] = 7;
      #1 check("t7 dec_ready stall", 64'(decReady), 64'(0));
      for (int k = 0; k < 2; k++) begin
         tick();
         check("t7 hold idex_valid", 64'(idexValid), 64'(2'b11));
         check("t7 hold rs1", 64'(idexRs1[1]), 64'(32'h1234));
         check("t7 hold cnt", 64'(hzCnt), 64'(6));
      end
      clearAll();

      // randomized traffic, checked by the model every cycle
      lastReady = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         lastReady = decReady;
         @(posedge clk);
         #2;
         rst_n    = ($urandom_range(0, 199) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         ex_stall = ($urandom_range(0, 9) == 0);
         for (int l = 0; l < N; l++) begin
            exRdWen[l]   = $urandom_range(0, 1) != 0;
            exIsLoad[l]  = $urandom_range(0, 3) == 0;
            exRdAddr[l]  = AW'($urandom_range(0, 7));
            exAlu[l]     = $urandom();
            memRdWen[l]  = $urandom_range(0, 1) != 0;
            memIsLoad[l] = $urandom_range(0, 2) == 0;
            memLdDone[l] = $urandom_range(0, 4) > 1;
            memRdAddr[l] = AW'($urandom_range(0, 7));
            memAlu[l]    = $urandom();
            dcache[l]    = $urandom();
            wbRdWen[l]   = $urandom_range(0, 1) != 0;
            wbRdAddr[l]  = AW'($urandom_range(0, 7));
            wbData[l]    = $urandom();
            rfRs1[l]     = $urandom();
            rfRs2[l]     = $urandom();
         end
         if (lastReady || $urandom_range(0, 9) == 0) begin
            for (int l = 0; l < N; l++) begin
               decValid[l]   = $urandom_range(0, 3) != 0;
               decRs1En[l]   = $urandom_range(0, 3) != 0;
               decRs2En[l]   = $urandom_range(0, 1) != 0;
               decRdWen[l]   = $urandom_range(0, 3) != 0;
               decRs1Addr[l] = AW'($urandom_range(0, 7));
               decRs2Addr[l] = AW'($urandom_range(0, 7));
               decRdAddr[l]  = AW'($urandom_range(0, 7));
            end
         end
      end
      rst_n = 1; flush = 0; ex_stall = 0;
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
